// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller:
// FSM state encoding, privilege levels, mstatus field positions and
// mcause codes, plus small helpers for mstatus packing and MPP legalisation.
package trap_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_RETURN   = 2'd3
  } trap_state_e;

  // Privilege encodings (10 is reserved and never held).
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // mstatus field positions handled by this block.
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;

  // Decoder exception vector bit positions.
  localparam int EXC_ILLEGAL_BIT = 2;
  localparam int EXC_ECALL_BIT   = 1;
  localparam int EXC_EBREAK_BIT  = 0;

  // mtvec mode field value selecting vectored interrupts.
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // mcause codes.
  localparam logic [63:0] CAUSE_ILLEGAL    = 64'd2;
  localparam logic [63:0] CAUSE_BREAKPOINT = 64'd3;
  localparam logic [63:0] CAUSE_ECALL_U    = 64'd8;
  localparam logic [63:0] CAUSE_ECALL_S    = 64'd9;
  localparam logic [63:0] CAUSE_ECALL_M    = 64'd11;
  localparam logic [63:0] CAUSE_M_EXT_IRQ  = 64'h8000_0000_0000_000B;

  // Reserved MPP encoding 10 is stored as U-mode.
  function automatic logic [1:0] legal_mpp(input logic [1:0] value);
    return (value == 2'b10) ? PRIV_U : value;
  endfunction

  // Build the visible mstatus word; unimplemented bits read as zero.
  function automatic logic [63:0] pack_mstatus(input logic       mie,
                                               input logic       mpie,
                                               input logic [1:0] mpp);
    logic [63:0] word;
    word                                 = '0;
    word[MSTATUS_MIE_BIT]                = mie;
    word[MSTATUS_MPIE_BIT]               = mpie;
    word[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = mpp;
    return word;
  endfunction

  // ecall cause depends on the privilege level the call is made from.
  function automatic logic [63:0] ecall_cause(input logic [1:0] priv);
    logic [63:0] cause;
    case (priv)
      PRIV_M:  cause = CAUSE_ECALL_M;
      PRIV_S:  cause = CAUSE_ECALL_S;
      default: cause = CAUSE_ECALL_U;
    endcase
    return cause;
  endfunction

endpackage

// File: rtl/trap_cause_enc.sv
// Combinational event selector: resolves interrupt/exception/mret priority
// and produces the cause and trap value for the winning event. Acceptance
// gating (IDLE, instruction valid, no stall) is left to the caller.
module trap_cause_enc
  import trap_pkg::*;
(
  input  logic [2:0]  i_except,
  input  logic        i_trap_return,
  input  logic        i_irq_pending,
  input  logic [1:0]  i_priv_mode,
  input  logic [63:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_take_trap,
  output logic        o_take_ret,
  output logic [63:0] o_cause,
  output logic [63:0] o_mtval
);

  logic w_mret_illegal;

  // An mret below M-mode is an illegal instruction, not a return.
  assign w_mret_illegal = i_trap_return && (i_priv_mode != PRIV_M);

  // Fixed priority: interrupt > illegal > ecall > ebreak > mret.
  // NOTE: every output gets a default before the priority chain so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    o_take_trap = 1'b0;
    o_take_ret  = 1'b0;
    o_cause     = '0;
    o_mtval     = '0;
    if (i_irq_pending) begin
      o_take_trap = 1'b1;
      o_cause     = CAUSE_M_EXT_IRQ;
    end else if (i_except[EXC_ILLEGAL_BIT] || (!i_except[EXC_ECALL_BIT] &&
                 !i_except[EXC_EBREAK_BIT] && w_mret_illegal)) begin
      o_take_trap = 1'b1;
      o_cause     = CAUSE_ILLEGAL;
      o_mtval     = {32'd0, i_instr};
    end else if (i_except[EXC_ECALL_BIT]) begin
      o_take_trap = 1'b1;
      o_cause     = ecall_cause(i_priv_mode);
    end else if (i_except[EXC_EBREAK_BIT]) begin
      o_take_trap = 1'b1;
      o_cause     = CAUSE_BREAKPOINT;
      o_mtval     = i_pc;
    end else if (i_trap_return) begin
      o_take_ret  = 1'b1;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller. Accepts one trap or mret per IDLE visit,
// records mepc/mcause/mtval, sequences the mstatus/privilege update, and
// issues a single-cycle pipeline flush with the redirect target.
module trap_ctrl
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  exceptSignal,
  input  logic        trapReturn,
  input  logic        instrValid,
  input  logic        coprocessorStall,
  input  logic        irqExt,
  input  logic        meie,
  input  logic [63:0] pcE,
  input  logic [31:0] instrE,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepcIn,
  input  logic        csrMstatusWe,
  input  logic [63:0] csrMstatusWdata,
  output logic [1:0]  privMode,
  output logic [63:0] mstatusOut,
  output logic        trapBusy,
  output logic        flush,
  output logic        redirectValid,
  output logic [63:0] redirectPC,
  output logic        trapCsrWe,
  output logic [63:0] mepcOut,
  output logic [63:0] mcauseOut,
  output logic [63:0] mtvalOut
);

  trap_state_e r_state;
  trap_state_e w_state_next;

  logic [1:0]  r_priv;
  logic        r_mie;
  logic        r_mpie;
  logic [1:0]  r_mpp;
  logic [63:0] r_mepc;
  logic [63:0] r_mcause;
  logic [63:0] r_mtval;

  logic        w_can_accept;
  logic        w_irq_pending;
  logic        w_take_trap;
  logic        w_take_ret;
  logic [63:0] w_cause;
  logic [63:0] w_mtval;
  logic        w_trap_acc;
  logic        w_ret_acc;
  logic [63:0] w_tvec_base;
  logic [63:0] w_tvec_offset;

  // Events are only sampled from a valid, unstalled instruction while idle;
  // anything presented during a sequence is dropped rather than queued.
  assign w_can_accept  = (r_state == ST_IDLE) && instrValid && !coprocessorStall;
  assign w_irq_pending = irqExt && meie && (r_mie || (r_priv != PRIV_M));

  trap_cause_enc u_cause_enc (
    .i_except      (exceptSignal),
    .i_trap_return (trapReturn),
    .i_irq_pending (w_irq_pending),
    .i_priv_mode   (r_priv),
    .i_pc          (pcE),
    .i_instr       (instrE),
    .o_take_trap   (w_take_trap),
    .o_take_ret    (w_take_ret),
    .o_cause       (w_cause),
    .o_mtval       (w_mtval)
  );

  assign w_trap_acc = w_can_accept && w_take_trap;
  assign w_ret_acc  = w_can_accept && w_take_ret;

  // Vectored mode only offsets interrupts; the recorded mcause MSB marks them.
  assign w_tvec_base   = {mtvec[63:2], 2'b00};
  assign w_tvec_offset = ((mtvec[1:0] == MTVEC_MODE_VECTORED) && r_mcause[63])
                         ? {56'd0, r_mcause[5:0], 2'b00} : 64'd0;

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state and per-state strobes; every strobe defaults low.
  always_comb begin
    w_state_next  = r_state;
    trapCsrWe     = 1'b0;
    flush         = 1'b0;
    redirectValid = 1'b0;
    redirectPC    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_trap_acc)     w_state_next = ST_CAPTURE;
        else if (w_ret_acc) w_state_next = ST_RETURN;
      end
      ST_CAPTURE: begin
        trapCsrWe    = 1'b1;
        w_state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        flush         = 1'b1;
        redirectValid = 1'b1;
        redirectPC    = w_tvec_base + w_tvec_offset;
        w_state_next  = ST_IDLE;
      end
      ST_RETURN: begin
        flush         = 1'b1;
        redirectValid = 1'b1;
        redirectPC    = {mepcIn[63:2], 2'b00};
        w_state_next  = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Trap record: captured only on an accepted trap, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (w_trap_acc) begin
      r_mepc   <= pcE;
      r_mcause <= w_cause;
      r_mtval  <= w_mtval;
    end
  end

  // Privilege and mstatus stack: trap entry/return updates take precedence;
  // software writes land only in IDLE cycles that accept no event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_priv <= PRIV_M;
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
      r_mpp  <= PRIV_U;
    end else begin
      case (r_state)
        ST_CAPTURE: begin
          r_mpie <= r_mie;
          r_mie  <= 1'b0;
          r_mpp  <= r_priv;
          r_priv <= PRIV_M;
        end
        ST_RETURN: begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
          r_priv <= r_mpp;
          r_mpp  <= PRIV_U;
        end
        ST_IDLE: begin
          if (csrMstatusWe && !w_trap_acc && !w_ret_acc) begin
            r_mie  <= csrMstatusWdata[MSTATUS_MIE_BIT];
            r_mpie <= csrMstatusWdata[MSTATUS_MPIE_BIT];
            r_mpp  <= legal_mpp(csrMstatusWdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
          end
        end
        default: ;
      endcase
    end
  end

  assign privMode   = r_priv;
  assign mstatusOut = pack_mstatus(r_mie, r_mpie, r_mpp);
  assign trapBusy   = (r_state != ST_IDLE);
  assign mepcOut    = r_mepc;
  assign mcauseOut  = r_mcause;
  assign mtvalOut   = r_mtval;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: exceptSignal  in  3  decoder exceptions: [2] illegal, [1] ecall, [0] ebreak.
REQ-004 SHALL have: trapReturn  in  1  mret decoded; instrValid  in  1  qualifies exceptSignal, trapReturn and interrupt sampling.
REQ-005 SHALL have: coprocessorStall  in  1  blocks acceptance of any trap or return.
REQ-006 SHALL have: irqExt  in  1  machine external interrupt; meie  in  1  its enable.
REQ-007 SHALL have: pcE  in  64  PC of the qualified instruction; instrE  in  32  its encoding.
REQ-008 SHALL have: mtvec  in  64  [63:2] base, [1:0] mode (00 direct, 01 vectored); mepcIn  in  64  current mepc.
REQ-009 SHALL have: csrMstatusWe  in  1; csrMstatusWdata  in  64  software mstatus write (MIE bit 3, MPIE bit 7, MPP bits 12:11).
REQ-010 SHALL have outputs: privMode 2; mstatusOut 64 (MIE/MPIE/MPP only, other bits 0); trapBusy 1; flush 1; redirectValid 1; redirectPC 64; trapCsrWe 1; mepcOut 64; mcauseOut 64; mtvalOut 64.

Function
REQ-011 SHALL implement FSM states IDLE, CAPTURE, REDIRECT, RETURN.
REQ-012 SHALL accept events only in IDLE with instrValid=1 and coprocessorStall=0; priority interrupt > illegal > ecall > ebreak > trapReturn.
REQ-013 Interrupt pending SHALL be irqExt & meie & (MIE | privMode!=11); cause 0x8000_0000_0000_000B, mtval 0.
REQ-014 Illegal: cause 2, mtval = zero-extended instrE; ecall: cause 8/9/11 for privMode 00/01/11, mtval 0; ebreak: cause 3, mtval = pcE.
REQ-015 trapReturn with privMode!=11 SHALL be treated as illegal (cause 2).
REQ-016 On acceptance of a trap: register pcE, cause, mtval into mepcOut/mcauseOut/mtvalOut; IDLE -> CAPTURE.
REQ-017 CAPTURE (1 cycle): trapCsrWe=1; at cycle end MPIE<=MIE, MIE<=0, MPP<=privMode, privMode<=11; -> REDIRECT.
REQ-018 REDIRECT (1 cycle): flush=1, redirectValid=1, redirectPC = {mtvec[63:2],00} + (mode==01 and interrupt ? 4*cause[5:0] : 0), 64-bit wrap; -> IDLE.
REQ-019 On accepted legal mret: IDLE -> RETURN; RETURN (1 cycle): flush=1, redirectValid=1, redirectPC = {mepcIn[63:2],00}; MIE<=MPIE, MPIE<=1, privMode<=MPP, MPP<=00; -> IDLE.
REQ-020 trapBusy SHALL be 1 exactly in CAPTURE, REDIRECT, RETURN; flush/redirectValid/trapCsrWe 0 in all other states.
REQ-021 Trap latency: acceptance cycle N -> trapCsrWe at N+1 -> redirect at N+2; mret redirect at N+1.
REQ-022 Events presented outside IDLE SHALL be ignored (not queued).
REQ-023 csrMstatusWe SHALL update MIE/MPIE/MPP only in IDLE when no event is accepted that cycle; trap/return updates win; MPP write value 10 SHALL store 00.
REQ-024 mepcOut/mcauseOut/mtvalOut SHALL hold their values until the next accepted trap.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, privMode=11, MIE=MPIE=0, MPP=00, and all other outputs 0.
REQ-026 Reset asserted mid-sequence SHALL abort it with no further strobe or redirect after release.

Structure
REQ-027 A shared package trap_pkg SHALL hold the state enum, cause code constants, privilege encodings (U=00, S=01, M=11) and mstatus bit positions.
REQ-028 One combinational sub-module trap_cause_enc SHALL perform event priority, cause and mtval selection.

Verification
REQ-029 privMode=11, ecall at pcE=0x1000, mtvec=0x8000 -> cycle N+1 trapCsrWe=1, mcause=11, mepc=0x1000; N+2 redirectPC=0x8000, flush=1; MIE=0, MPP=11.
REQ-030 mtvec=0x8001, MIE=1, meie=1, irqExt=1 with illegal pending -> interrupt taken, mcause=0x8000_0000_0000_000B, redirectPC=0x802C.
REQ-031 Illegal instrE=0xFFFFFFFF -> mcause=2, mtval=0x0000_0000_FFFF_FFFF; ebreak at 0x2000 -> mcause=3, mtval=0x2000.
REQ-032 MPP=00, MPIE=1, mret, mepcIn=0x4002 -> N+1 redirectPC=0x4000, privMode=00, MIE=1; then mret in U-mode -> mcause=2.
REQ-033 csrMstatusWe together with accepted trap -> trap values win; coprocessorStall=1 with ecall -> no action.
REQ-034 reset_n low during CAPTURE -> outputs immediately at reset values; no redirect after release.
